// File: rtl/sample_pacer_pkg.sv
// Shared types for the sample pacer: playout state, status word for the register map,
// and the saturating counter helper.
package sample_pacer_pkg;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } PACER_STATE;

   localparam int STATUS_W = 16;

   typedef struct packed {
      logic [STATUS_W-1:0] Fill;
      logic [STATUS_W-1:0] Underruns;
   } PACER_STATUS;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO: head always presents the entry at the read pointer.
// Storage has no reset so it maps onto distributed RAM.
module sample_fifo #(
   parameter int WIDTH      = 16,
   parameter int LOG2_DEPTH = 4
) (
   input  logic                  ipClk,
   input  logic                  Reset,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [WIDTH-1:0]      i_data,
   output logic [WIDTH-1:0]      o_head,
   output logic [LOG2_DEPTH:0]   o_fill
);

   localparam int DEPTH = 2**LOG2_DEPTH;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [LOG2_DEPTH-1:0] r_wr_ptr;
   logic [LOG2_DEPTH-1:0] r_rd_ptr;
   logic [LOG2_DEPTH:0]   r_fill;

   always_ff @(posedge ipClk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers are exactly LOG2_DEPTH bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge ipClk) begin
      if (Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_fill <= r_fill + (LOG2_DEPTH+1)'(i_push) - (LOG2_DEPTH+1)'(i_pop);
      end
   end

   assign o_head = r_mem[r_rd_ptr];
   assign o_fill = r_fill;

endmodule

// File: rtl/sample_pacer.sv
// Buffers bursty samples and releases one per CLOCK_DIV cycles; primes to half-full,
// holds the last sample on underrun and re-primes.
module sample_pacer
   import sample_pacer_pkg::*;
#(
   parameter int CLOCK_DIV  = 1042,
   parameter int LOG2_DEPTH = 4
) (
   input  logic                ipClk,
   input  logic                Reset,
   input  logic [15:0]         ipData,
   input  logic                ipValid,
   output logic                opReady,
   output logic [15:0]         opSample,
   output logic                opSampleValid,
   output logic [LOG2_DEPTH:0] opFill,
   output logic [15:0]         opUnderruns,
   output logic                opRunning
);

   localparam int                  DEPTH     = 2**LOG2_DEPTH;
   localparam int                  CW        = $clog2(CLOCK_DIV);
   localparam logic [CW-1:0]       TICK_LAST = CW'(CLOCK_DIV - 1);
   localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH+1)'(DEPTH);
   localparam logic [LOG2_DEPTH:0] FILL_HALF = (LOG2_DEPTH+1)'(DEPTH / 2);

   logic [CW-1:0]       r_tick_cnt;
   logic                w_tick;
   PACER_STATE          r_state;
   PACER_STATE          w_state_nxt;
   logic                w_push;
   logic                w_pop;
   logic                w_underrun;
   logic [15:0]         w_head;
   logic [LOG2_DEPTH:0] w_fill;
   logic [15:0]         r_sample;
   logic                r_sample_vld;
   logic [15:0]         r_underruns;

   sample_fifo #(
      .WIDTH      (16),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_fifo (
      .ipClk  (ipClk),
      .Reset  (Reset),
      .i_push (w_push),
      .i_pop  (w_pop),
      .i_data (ipData),
      .o_head (w_head),
      .o_fill (w_fill)
   );

   assign opReady = !Reset && (w_fill != FILL_FULL);
   assign w_push  = ipValid && opReady;
   assign w_tick  = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge ipClk) begin
      if (Reset || w_tick) r_tick_cnt <= '0;
      else                 r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   always_ff @(posedge ipClk) begin
      if (Reset) r_state <= PRIME;
      else       r_state <= w_state_nxt;
   end

   // PRIME leaves on the registered fill every cycle; a tick in PRIME only strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_underrun  = 1'b0;
      case (r_state)
         PRIME: if (w_fill >= FILL_HALF) w_state_nxt = RUN;
         RUN: begin
            if (w_tick) begin
               if (w_fill != '0) begin
                  w_pop = 1'b1;
               end else begin
                  w_underrun  = 1'b1;
                  w_state_nxt = PRIME;
               end
            end
         end
         default: w_state_nxt = PRIME;
      endcase
   end

   always_ff @(posedge ipClk) begin
      if (Reset) begin
         r_sample     <= '0;
         r_sample_vld <= 1'b0;
         r_underruns  <= '0;
      end else begin
         r_sample_vld <= w_tick;
         if (w_pop)      r_sample    <= w_head;
         if (w_underrun) r_underruns <= sat_inc16(r_underruns);
      end
   end

   assign opSample      = r_sample;
   assign opSampleValid = r_sample_vld;
   assign opUnderruns   = r_underruns;
   assign opRunning     = (r_state == RUN);
   assign opFill        = w_fill;

endmodule

// File: tb/tb_sample_pacer.sv
// Randomized scoreboard bench for sample_pacer: a queue-based playout model predicts each
// output strobe and the per-cycle fill/ready/running view.
module tb_sample_pacer;

   localparam int CD    = 4;
   localparam int L2    = 4;
   localparam int DEPTH = 16;

   logic        ipClk = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] ipData = '0;
   logic        ipValid = 1'b0;
   logic        opReady;
   logic [15:0] opSample;
   logic        opSampleValid;
   logic [L2:0] opFill;
   logic [15:0] opUnderruns;
   logic        opRunning;

   always #5 ipClk = ~ipClk;

   sample_pacer #(.CLOCK_DIV(CD), .LOG2_DEPTH(L2)) dut (
      .ipClk         (ipClk),
      .Reset         (Reset),
      .ipData        (ipData),
      .ipValid       (ipValid),
      .opReady       (opReady),
      .opSample      (opSample),
      .opSampleValid (opSampleValid),
      .opFill        (opFill),
      .opUnderruns   (opUnderruns),
      .opRunning     (opRunning)
   );

   typedef struct {
      logic [15:0] smp;
      logic [15:0] und;
      bit          run;
   } strobe_t;

   strobe_t     sb[$];
   logic [15:0] mq[$];
   int          m_tc;
   bit          m_run;
   logic [15:0] m_smp;
   logic [15:0] m_und;
   bit          exp_vld;
   bit          started;
   int          m_f;
   bit          m_tick;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a sample queue drained once per period while playing.
   always @(posedge ipClk) begin
      started = 1'b1;
      if (Reset) begin
         mq.delete();
         m_tc    = 0;
         m_run   = 1'b0;
         m_smp   = '0;
         m_und   = '0;
         exp_vld = 1'b0;
      end else begin
         m_f    = mq.size();
         m_tick = (m_tc == CD - 1);
         m_tc   = (m_tc + 1) % CD;
         if (m_tick && m_run) begin
            if (m_f != 0) m_smp = mq.pop_front();
            else if (m_und != 16'hFFFF) m_und = m_und + 16'd1;
         end
         if (ipValid && m_f != DEPTH) mq.push_back(ipData);
         if (!m_run && m_f >= DEPTH / 2)       m_run = 1'b1;
         else if (m_run && m_tick && m_f == 0) m_run = 1'b0;
         exp_vld = m_tick;
         if (m_tick) sb.push_back('{m_smp, m_und, m_run});
      end
   end

   // Monitor: strobes pop the scoreboard; fill/ready/running checked every cycle.
   always @(negedge ipClk) begin
      if (started) begin
         chk("fill",    32'(opFill),        32'(mq.size()));
         chk("ready",   32'(opReady),       32'(!Reset && mq.size() != DEPTH));
         chk("running", 32'(opRunning),     32'(m_run));
         chk("strobe",  32'(opSampleValid), 32'(exp_vld));
         if (opSampleValid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("strobe_expected", 32'(0), 32'(1));
            end else begin
               strobe_t e;
               e = sb.pop_front();
               chk("sample",    32'(opSample),    32'(e.smp));
               chk("underruns", 32'(opUnderruns), 32'(e.und));
               chk("run_at_strobe", 32'(opRunning), 32'(e.run));
            end
         end
      end
   end

   task automatic cyc(input bit v, input logic [15:0] d, input bit r);
      @(posedge ipClk);
      #1;
      ipValid = v;
      ipData  = d;
      Reset   = r;
   endtask

   initial begin
      int p;
      logic [15:0] seq;
      repeat (2) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      // idle after reset: strobes with sample 0, no running
      repeat (40) cyc(1'b0, '0, 1'b0);
      // prime with 1..8 then starve into underruns
      for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0);
      repeat (60) cyc(1'b0, '0, 1'b0);
      for (int i = 9; i <= 16; i++) cyc(1'b1, 16'(i), 1'b0);
      repeat (10) cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b1);
      // sustained input to hit full and back-pressure
      seq = 16'h8000;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, seq, 1'b0);
         seq = seq + 16'd3;
      end
      repeat (80) cyc(1'b0, '0, 1'b0);
      // randomized bursts with varying density and occasional resets
      for (int blk = 0; blk < 15; blk++) begin
         p = $urandom_range(0, 100);
         for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 99) < p, 16'($urandom), $urandom_range(0, 999) < 3);
      end
      repeat (8) cyc(1'b0, '0, 1'b0);
      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
